// File: rtl/reg_file_cmd_ctrl.sv
// Byte-stream command sequencer: decodes write/read frames from UART RX, drives the
// register file access port and returns read data on UART TX.
module reg_file_cmd_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter logic [7:0]  WR_CMD     = 8'hAA,
    parameter logic [7:0]  RD_CMD     = 8'hBB,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [7:0]            RdData,
    input  logic                  RdData_Valid,
    input  logic                  TX_BUSY,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [7:0]            WrData,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CTRL_BUSY,
    output logic                  CMD_ERR
);

    localparam int unsigned     CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_REQ,
        RD_WAIT,
        TX_SEND
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wrdata_q, wrdata_d;
    logic [7:0]            txdata_q, txdata_d;
    logic [7:0]            buf_q, buf_d;
    logic                  wren_q, wren_d;
    logic                  rden_q, rden_d;
    logic                  txvld_q, txvld_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic timed_out;
    logic addr_bad;
    logic counting;

    assign timed_out = (cnt_q == CNT_LAST);
    assign addr_bad  = ((RX_P_DATA >> ADDR_WIDTH) != 8'h00);
    assign counting  = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                       (state_q == RD_ADDR) || (state_q == RD_WAIT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        txdata_d = txdata_q;
        buf_d    = buf_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        txvld_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state_d = RD_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_ADDR, RD_ADDR: begin
                // Timeout takes priority over a byte arriving in the same cycle.
                if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (RX_D_VLD) begin
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                        state_d = (state_q == WR_ADDR) ? WR_DATA : RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (RX_D_VLD) begin
                    wrdata_d = RX_P_DATA;
                    wren_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_REQ: begin
                rden_d  = 1'b1;
                err_d   = RX_D_VLD;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d = RX_D_VLD;
                    // RdEn is still high on the first RD_WAIT cycle; valid is only trusted after it.
                    if (!rden_q && RdData_Valid) begin
                        buf_d   = RdData;
                        state_d = TX_SEND;
                    end
                end
            end
            TX_SEND: begin
                err_d = RX_D_VLD;
                if (!TX_BUSY) begin
                    txvld_d  = 1'b1;
                    txdata_d = buf_q;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d != state_q) || RX_D_VLD) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            txdata_q <= '0;
            buf_q    <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            txvld_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            txdata_q <= txdata_d;
            buf_q    <= buf_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            txvld_q  <= txvld_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign WrEn      = wren_q;
    assign RdEn      = rden_q;
    assign Address   = addr_q;
    assign WrData    = wrdata_q;
    assign TX_P_DATA = txdata_q;
    assign TX_D_VLD  = txvld_q;
    assign CTRL_BUSY = busy_q;
    assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Directed bench for reg_file_cmd_ctrl: write, read, TX backpressure, frame errors,
// timeout and mid-frame reset.
module tb_reg_file_cmd_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned TO = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [7:0]    RX_P_DATA = 8'h00;
    logic          RX_D_VLD = 1'b0;
    logic [7:0]    RdData = 8'h00;
    logic          RdData_Valid = 1'b0;
    logic          TX_BUSY = 1'b0;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [7:0]    WrData;
    logic [7:0]    TX_P_DATA;
    logic          TX_D_VLD;
    logic          CTRL_BUSY;
    logic          CMD_ERR;

    int total = 0;
    int bad   = 0;

    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int tx_cnt   = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    int w0, r0, t0, e0;

    reg_file_cmd_ctrl #(
        .ADDR_WIDTH(AW),
        .WR_CMD    (8'hAA),
        .RD_CMD    (8'hBB),
        .TIMEOUT   (TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .RdData      (RdData),
        .RdData_Valid(RdData_Valid),
        .TX_BUSY     (TX_BUSY),
        .WrEn        (WrEn),
        .RdEn        (RdEn),
        .Address     (Address),
        .WrData      (WrData),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD),
        .CTRL_BUSY   (CTRL_BUSY),
        .CMD_ERR     (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge CLK) begin
        #1;
        if (WrEn)          wr_cnt++;
        if (RdEn)          rd_cnt++;
        if (TX_D_VLD)      tx_cnt++;
        if (CMD_ERR)       err_cnt++;
        if (WrEn && RdEn)  both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wren"},  32'(WrEn),      32'h0);
        check({tag, "_rden"},  32'(RdEn),      32'h0);
        check({tag, "_addr"},  32'(Address),   32'h0);
        check({tag, "_wdata"}, 32'(WrData),    32'h0);
        check({tag, "_txd"},   32'(TX_P_DATA), 32'h0);
        check({tag, "_txv"},   32'(TX_D_VLD),  32'h0);
        check({tag, "_busy"},  32'(CTRL_BUSY), 32'h0);
        check({tag, "_err"},   32'(CMD_ERR),   32'h0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check_all_zero("reset");

        // Write AA,05,3C
        send(8'hAA);
        check("wr_busy_after_cmd", 32'(CTRL_BUSY), 32'h1);
        send(8'h05);
        w0 = wr_cnt;
        send(8'h3C);
        check("wr_en",    32'(WrEn),      32'h1);
        check("wr_addr",  32'(Address),   32'h5);
        check("wr_data",  32'(WrData),    32'h3C);
        check("wr_busy",  32'(CTRL_BUSY), 32'h0);
        @(negedge CLK);
        check("wr_en_off",  32'(WrEn),       32'h0);
        check("wr_pulses",  32'(wr_cnt - w0), 32'h1);

        // Read BB,05 with data returned the cycle after RdEn
        r0 = rd_cnt;
        t0 = tx_cnt;
        send(8'hBB);
        send(8'h05);
        check("rd_en_early", 32'(RdEn), 32'h0);
        @(negedge CLK);
        check("rd_en",   32'(RdEn),    32'h1);
        check("rd_addr", 32'(Address), 32'h5);
        @(negedge CLK);
        check("rd_en_off", 32'(RdEn), 32'h0);
        RdData       = 8'h3C;
        RdData_Valid = 1'b1;
        @(negedge CLK);
        RdData_Valid = 1'b0;
        RdData       = 8'h00;
        check("rd_txv_early", 32'(TX_D_VLD), 32'h0);
        @(negedge CLK);
        check("rd_txv",  32'(TX_D_VLD),  32'h1);
        check("rd_txd",  32'(TX_P_DATA), 32'h3C);
        check("rd_busy", 32'(CTRL_BUSY), 32'h0);
        @(negedge CLK);
        check("rd_txv_off",  32'(TX_D_VLD),     32'h0);
        check("rd_pulses",   32'(rd_cnt - r0),  32'h1);
        check("tx_pulses",   32'(tx_cnt - t0),  32'h1);

        // Read with TX backpressure for 20 cycles, plus a stray byte dropped in TX_SEND
        TX_BUSY = 1'b1;
        send(8'hBB);
        send(8'h07);
        @(negedge CLK);
        check("bp_rd_en", 32'(RdEn), 32'h1);
        @(negedge CLK);
        RdData       = 8'hA5;
        RdData_Valid = 1'b1;
        @(negedge CLK);
        RdData_Valid = 1'b0;
        t0 = tx_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 20; i++) begin
            RX_P_DATA = 8'h99;
            RX_D_VLD  = (i == 5);
            @(negedge CLK);
        end
        RX_D_VLD = 1'b0;
        check("bp_no_tx",   32'(tx_cnt - t0),  32'h0);
        check("bp_busy",    32'(CTRL_BUSY),    32'h1);
        check("bp_drop_err", 32'(err_cnt - e0), 32'h1);
        TX_BUSY = 1'b0;
        @(negedge CLK);
        check("bp_txv", 32'(TX_D_VLD),  32'h1);
        check("bp_txd", 32'(TX_P_DATA), 32'hA5);
        @(negedge CLK);
        check("bp_txv_off", 32'(TX_D_VLD),    32'h0);
        check("bp_pulses",  32'(tx_cnt - t0), 32'h1);

        // Unknown command byte
        send(8'h7E);
        check("bad_cmd_err",  32'(CMD_ERR),   32'h1);
        check("bad_cmd_busy", 32'(CTRL_BUSY), 32'h0);
        @(negedge CLK);
        check("bad_cmd_err_off", 32'(CMD_ERR), 32'h0);

        // Address out of range
        w0 = wr_cnt;
        send(8'hAA);
        send(8'h15);
        check("bad_addr_err",  32'(CMD_ERR),   32'h1);
        check("bad_addr_busy", 32'(CTRL_BUSY), 32'h0);
        @(negedge CLK);
        check("bad_addr_nowr", 32'(wr_cnt - w0), 32'h0);

        // Timeout in WR_DATA, then a normal write
        w0 = wr_cnt;
        send(8'hAA);
        send(8'h05);
        repeat (TO - 1) @(negedge CLK);
        check("to_err_early", 32'(CMD_ERR),   32'h0);
        check("to_busy_early", 32'(CTRL_BUSY), 32'h1);
        @(negedge CLK);
        check("to_err",  32'(CMD_ERR),   32'h1);
        check("to_busy", 32'(CTRL_BUSY), 32'h0);
        @(negedge CLK);
        check("to_nowr", 32'(wr_cnt - w0), 32'h0);
        send(8'hAA);
        send(8'h02);
        send(8'h11);
        check("to_wr_en",   32'(WrEn),    32'h1);
        check("to_wr_addr", 32'(Address), 32'h2);
        check("to_wr_data", 32'(WrData),  32'h11);
        @(negedge CLK);
        check("to_wr_pulses", 32'(wr_cnt - w0), 32'h1);

        // Reset between address and data of a write
        w0 = wr_cnt;
        send(8'hAA);
        send(8'h05);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_all_zero("rst_mid");
        send(8'h3C);
        check("rst_orphan_err",  32'(CMD_ERR), 32'h1);
        check("rst_orphan_nowr", 32'(WrEn),    32'h0);
        @(negedge CLK);
        check("rst_nowr", 32'(wr_cnt - w0), 32'h0);

        check("wr_rd_exclusive", 32'(both_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
